// File: rtl/pipeline_data_cache_pkg.sv
// pipeline_data_cache_pkg
//   Shared constants and types for the MEM-stage data cache:
//   default geometry (word size, line count, words per line), the
//   address-field widths/positions derived from that geometry, and the
//   controller state encoding.
package pipeline_data_cache_pkg;

    localparam int unsigned WORD_SIZE      = 16;
    localparam int unsigned LINES          = 4;
    localparam int unsigned WORDS_PER_LINE = 4;

    // Address layout: {tag, index, offset}
    localparam int unsigned OFFSET_W   = $clog2(WORDS_PER_LINE);
    localparam int unsigned INDEX_W    = $clog2(LINES);
    localparam int unsigned TAG_W      = WORD_SIZE - OFFSET_W - INDEX_W;
    localparam int unsigned OFFSET_LSB = 0;
    localparam int unsigned INDEX_LSB  = OFFSET_W;
    localparam int unsigned TAG_LSB    = OFFSET_W + INDEX_W;
    localparam int unsigned LINE_W     = WORD_SIZE * WORDS_PER_LINE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/pipeline_data_cache_array.sv
// cache_tag_data_array
//   Valid/tag/data storage for a direct-mapped cache.
//   Ports:
//     clk, reset_n            clock; async active-low clear of valid bits
//     lookup_addr             word address to look up (combinational)
//     lookup_hit, lookup_word hit flag and addressed word of that line
//     fill_en/index/tag/line  whole-line write, marks the line valid
//     write_en/index/offset/data  single-word update of a resident line
module cache_tag_data_array
    import pipeline_data_cache_pkg::*;
#(
    parameter int unsigned WORD_SIZE      = pipeline_data_cache_pkg::WORD_SIZE,
    parameter int unsigned LINES          = pipeline_data_cache_pkg::LINES,
    parameter int unsigned WORDS_PER_LINE = pipeline_data_cache_pkg::WORDS_PER_LINE
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [WORD_SIZE-1:0]                 lookup_addr,
    output logic                                 lookup_hit,
    output logic [WORD_SIZE-1:0]                 lookup_word,
    input  logic                                 fill_en,
    input  logic [$clog2(LINES)-1:0]             fill_index,
    input  logic [WORD_SIZE-$clog2(LINES)-$clog2(WORDS_PER_LINE)-1:0] fill_tag,
    input  logic [WORD_SIZE*WORDS_PER_LINE-1:0]  fill_line,
    input  logic                                 write_en,
    input  logic [$clog2(LINES)-1:0]             write_index,
    input  logic [$clog2(WORDS_PER_LINE)-1:0]    write_offset,
    input  logic [WORD_SIZE-1:0]                 write_data
);

    localparam int unsigned OFF_BITS = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX_BITS = $clog2(LINES);
    localparam int unsigned TAG_BITS = WORD_SIZE - OFF_BITS - IDX_BITS;
    localparam int unsigned LINE_BITS = WORD_SIZE * WORDS_PER_LINE;

    logic [LINES-1:0]     valid;
    logic [TAG_BITS-1:0]  tags  [LINES];
    logic [LINE_BITS-1:0] lines [LINES];

    logic [OFF_BITS-1:0] lk_off;
    logic [IDX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0] lk_tag;

    assign lk_off = lookup_addr[OFF_BITS-1:0];
    assign lk_idx = lookup_addr[OFF_BITS +: IDX_BITS];
    assign lk_tag = lookup_addr[WORD_SIZE-1 -: TAG_BITS];

    always_comb begin
        lookup_hit  = valid[lk_idx] && (tags[lk_idx] == lk_tag);
        lookup_word = lines[lk_idx][lk_off*WORD_SIZE +: WORD_SIZE];
    end

    // Only the valid bits need clearing; tag/data are qualified by them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[fill_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tags[fill_index]  <= fill_tag;
            lines[fill_index] <= fill_line;
        end else if (write_en) begin
            lines[write_index][write_offset*WORD_SIZE +: WORD_SIZE] <= write_data;
        end
    end

endmodule

// File: rtl/pipeline_data_cache.sv
// pipeline_data_cache
//   Direct-mapped, write-through, no-write-allocate data cache for the
//   MEM stage. Read hits complete combinationally; read misses fill a
//   whole line; every write goes through to memory as one word.
//   Ports:
//     clk, reset_n                      clock, async active-low reset
//     cpu_read/cpu_write/cpu_addr/cpu_wdata  core request (held until ready)
//     cpu_rdata, cpu_ready              read data, completion (stall = !ready)
//     mem_read/mem_write/mem_addr/mem_wdata  line-fill / write-through request
//     mem_rdata, mem_ready              returned line, memory completion
//     hit_count, miss_count             saturating access statistics
module pipeline_data_cache
    import pipeline_data_cache_pkg::*;
#(
    parameter int unsigned WORD_SIZE      = pipeline_data_cache_pkg::WORD_SIZE,
    parameter int unsigned LINES          = pipeline_data_cache_pkg::LINES,
    parameter int unsigned WORDS_PER_LINE = pipeline_data_cache_pkg::WORDS_PER_LINE
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                cpu_read,
    input  logic                                cpu_write,
    input  logic [WORD_SIZE-1:0]                cpu_addr,
    input  logic [WORD_SIZE-1:0]                cpu_wdata,
    output logic [WORD_SIZE-1:0]                cpu_rdata,
    output logic                                cpu_ready,
    output logic                                mem_read,
    output logic                                mem_write,
    output logic [WORD_SIZE-1:0]                mem_addr,
    output logic [WORD_SIZE-1:0]                mem_wdata,
    input  logic [WORD_SIZE*WORDS_PER_LINE-1:0] mem_rdata,
    input  logic                                mem_ready,
    output logic [15:0]                         hit_count,
    output logic [15:0]                         miss_count
);

    localparam int unsigned OFF_BITS = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX_BITS = $clog2(LINES);
    localparam int unsigned TAG_BITS = WORD_SIZE - OFF_BITS - IDX_BITS;

    state_t state, next_state;

    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic                 refill_flag;

    logic                 lookup_hit;
    logic [WORD_SIZE-1:0] lookup_word;
    logic                 fill_en;
    logic                 write_en;
    logic                 count_hit;
    logic                 count_miss;
    logic                 latch_req;
    logic                 clear_refill;

    cache_tag_data_array #(
        .WORD_SIZE      (WORD_SIZE),
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_array (
        .clk          (clk),
        .reset_n      (reset_n),
        .lookup_addr  (cpu_addr),
        .lookup_hit   (lookup_hit),
        .lookup_word  (lookup_word),
        .fill_en      (fill_en),
        .fill_index   (addr_q[OFF_BITS +: IDX_BITS]),
        .fill_tag     (addr_q[WORD_SIZE-1 -: TAG_BITS]),
        .fill_line    (mem_rdata),
        .write_en     (write_en),
        .write_index  (cpu_addr[OFF_BITS +: IDX_BITS]),
        .write_offset (cpu_addr[OFF_BITS-1:0]),
        .write_data   (cpu_wdata)
    );

    always_comb begin
        next_state   = state;
        cpu_ready    = 1'b0;
        cpu_rdata    = '0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        fill_en      = 1'b0;
        write_en     = 1'b0;
        count_hit    = 1'b0;
        count_miss   = 1'b0;
        latch_req    = 1'b0;
        clear_refill = 1'b0;
        unique case (state)
            IDLE: begin
                // Write has priority over a simultaneous read.
                if (cpu_write) begin
                    next_state = WRITE;
                    latch_req  = 1'b1;
                    write_en   = lookup_hit;
                    count_hit  = lookup_hit;
                    count_miss = !lookup_hit;
                end else if (cpu_read) begin
                    if (lookup_hit) begin
                        cpu_ready    = 1'b1;
                        cpu_rdata    = lookup_word;
                        // The hit that completes a refilled read was already
                        // counted as a miss.
                        count_hit    = !refill_flag;
                        clear_refill = 1'b1;
                    end else begin
                        next_state = FILL;
                        latch_req  = 1'b1;
                        count_miss = 1'b1;
                    end
                end
            end
            FILL: begin
                mem_read = 1'b1;
                // Full address is latched; the offset is masked here so the
                // same register serves both fill and write-through.
                mem_addr = {addr_q[WORD_SIZE-1:OFF_BITS], {OFF_BITS{1'b0}}};
                if (mem_ready) begin
                    fill_en    = 1'b1;
                    next_state = IDLE;
                end
            end
            WRITE: begin
                mem_write = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                cpu_ready = mem_ready;
                if (mem_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            refill_flag <= 1'b0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            state <= next_state;
            if (latch_req) begin
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
            end
            if (fill_en) begin
                refill_flag <= 1'b1;
            end else if (clear_refill) begin
                refill_flag <= 1'b0;
            end
            if (count_hit && (hit_count != '1)) begin
                hit_count <= hit_count + 16'd1;
            end
            if (count_miss && (miss_count != '1)) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_data_cache.sv
// tb_pipeline_data_cache
//   Directed bench for pipeline_data_cache. A word-addressed memory array
//   with fixed latency answers fill/write requests; because the cache is
//   write-through, any completed read must return the memory array's word.
//   A tag/valid model predicts hit or miss, stall length and counters.
module tb_pipeline_data_cache;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    always #5 clk = ~clk;

    pipeline_data_cache #(
        .WORD_SIZE      (16),
        .LINES          (4),
        .WORDS_PER_LINE (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_read   (cpu_read),
        .cpu_write  (cpu_write),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    logic [15:0] mem [256];
    int          checks = 0;
    int          errors = 0;

    bit          mvalid [4];
    logic [11:0] mtag   [4];
    logic [15:0] exp_hit  = '0;
    logic [15:0] exp_miss = '0;

    logic [15:0] last_rdata, last_maddr, last_mwdata;
    int          last_stall, last_nmr, last_nmw;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Memory responder: mem_ready on the LAT-th cycle of a request.
    int rcnt = 0;
    always @(negedge clk) begin
        logic [7:0] base;
        if (reset_n && (mem_read || mem_write)) begin
            rcnt++;
            if (rcnt == LAT) begin
                rcnt = 0;
                mem_ready = 1'b1;
                if (mem_write) mem[mem_addr[7:0]] = mem_wdata;
                if (mem_read) begin
                    base = {mem_addr[7:2], 2'b00};
                    mem_rdata = {mem[base+8'd3], mem[base+8'd2], mem[base+8'd1], mem[base]};
                end
            end else begin
                mem_ready = 1'b0;
            end
        end else begin
            rcnt = 0;
            mem_ready = 1'b0;
        end
    end

    // Per-cycle checks of output rules against the memory image.
    always @(negedge clk) begin
        #2;
        if (reset_n) begin
            check("mem_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
            if (cpu_ready && cpu_read && !cpu_write)
                check("rdata_vs_mem", cpu_rdata, mem[cpu_addr[7:0]]);
            else
                check("rdata_idle_zero", cpu_rdata, 32'd0);
            if (mem_read)
                check("fill_addr", mem_addr, {cpu_addr[15:2], 2'b00});
            if (mem_write) begin
                check("wt_addr", mem_addr, cpu_addr);
                check("wt_data", mem_wdata, cpu_wdata);
            end
        end
    end

    task automatic access(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        logic [1:0]  idx;
        logic [11:0] tg;
        bit          hit;
        int          exp_stall, exp_nmr, exp_nmw;
        idx = a[3:2];
        tg  = a[15:4];
        hit = mvalid[idx] && (mtag[idx] == tg);
        @(posedge clk); #1;
        cpu_read = rd; cpu_write = wr; cpu_addr = a; cpu_wdata = d;
        last_stall = 0; last_nmr = 0; last_nmw = 0;
        forever begin
            @(negedge clk); #2;
            if (mem_read)  begin last_nmr++; last_maddr = mem_addr; end
            if (mem_write) begin last_nmw++; last_maddr = mem_addr; last_mwdata = mem_wdata; end
            if (cpu_ready) break;
            last_stall++;
            if (last_stall > 40) begin
                check("ready_timeout", 32'd1, 32'd0);
                break;
            end
        end
        last_rdata = cpu_rdata;
        if (wr) begin
            exp_stall = LAT; exp_nmr = 0; exp_nmw = LAT;
            if (hit) exp_hit = sat_inc(exp_hit);
            else     exp_miss = sat_inc(exp_miss);
        end else if (hit) begin
            exp_stall = 0; exp_nmr = 0; exp_nmw = 0;
            exp_hit = sat_inc(exp_hit);
        end else begin
            exp_stall = LAT + 1; exp_nmr = LAT; exp_nmw = 0;
            exp_miss = sat_inc(exp_miss);
            mvalid[idx] = 1'b1;
            mtag[idx]   = tg;
        end
        check("stall_cycles", last_stall, exp_stall);
        check("mem_read_cycles", last_nmr, exp_nmr);
        check("mem_write_cycles", last_nmw, exp_nmw);
        @(posedge clk); #1;
        cpu_read = 1'b0; cpu_write = 1'b0;
        check("hit_count", hit_count, exp_hit);
        check("miss_count", miss_count, exp_miss);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i) + 16'hAA7C;
        for (int i = 0; i < 4; i++) begin mvalid[i] = 1'b0; mtag[i] = '0; end

        #2;
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_hits", hit_count, 0);
        check("rst_misses", miss_count, 0);
        #10 reset_n = 1'b1;

        // Cold read: line 0x24..0x27 = AAA0..AAA3
        access(1'b1, 1'b0, 16'h0025, 16'h0);
        check("cold_fill_addr", last_maddr, 16'h0024);
        check("cold_rdata", last_rdata, 16'hAAA1);
        check("cold_stall", last_stall, 4);
        check("cold_miss", miss_count, 1);
        check("cold_hit", hit_count, 0);

        // Spatial hit
        access(1'b1, 1'b0, 16'h0026, 16'h0);
        check("spatial_rdata", last_rdata, 16'hAAA2);
        check("spatial_stall", last_stall, 0);
        check("spatial_hit", hit_count, 1);

        // Write-through hit
        access(1'b0, 1'b1, 16'h0026, 16'h1234);
        check("wt_mem_addr", last_maddr, 16'h0026);
        check("wt_mem_wdata", last_mwdata, 16'h1234);
        check("wt_hit", hit_count, 2);
        access(1'b1, 1'b0, 16'h0026, 16'h0);
        check("wt_readback", last_rdata, 16'h1234);
        check("wt_readback_nofill", last_nmr, 0);

        // Conflict, no-allocate, eviction
        access(1'b0, 1'b1, 16'h0066, 16'h7777);
        access(1'b1, 1'b0, 16'h0066, 16'h0);
        check("conflict_fill_addr", last_maddr, 16'h0064);
        check("conflict_rdata", last_rdata, 16'h7777);
        access(1'b1, 1'b0, 16'h0026, 16'h0);
        check("evict_refill_rdata", last_rdata, 16'h1234);
        check("conflict_misses", miss_count, 4);
        check("conflict_hits", hit_count, 3);

        // Read+write together: write only
        access(1'b1, 1'b1, 16'h0025, 16'h5555);
        check("prio_no_fill", last_nmr, 0);
        check("prio_wdata", last_mwdata, 16'h5555);
        check("prio_hits", hit_count, 4);
        access(1'b1, 1'b0, 16'h0025, 16'h0);
        check("prio_readback", last_rdata, 16'h5555);

        // Saturation: held read hits once per cycle
        @(posedge clk); #1;
        cpu_read = 1'b1; cpu_addr = 16'h0025;
        repeat (65540) @(posedge clk);
        #1 cpu_read = 1'b0;
        for (int i = 0; i < 65540; i++) exp_hit = sat_inc(exp_hit);
        check("sat_hits_model", hit_count, exp_hit);
        check("sat_hits", hit_count, 16'hFFFF);
        access(1'b1, 1'b0, 16'h0024, 16'h0);
        check("sat_hold", hit_count, 16'hFFFF);
        check("sat_rdata", last_rdata, 16'hAAA0);

        // Reset in the middle of a fill
        @(posedge clk); #1;
        cpu_read = 1'b1; cpu_addr = 16'h0045;
        @(posedge clk); #3;
        check("midfill_active", mem_read, 1);
        reset_n = 1'b0;
        #1;
        check("midfill_mem_read", mem_read, 0);
        check("midfill_cpu_ready", cpu_ready, 0);
        check("midfill_hits", hit_count, 0);
        check("midfill_misses", miss_count, 0);
        cpu_read = 1'b0;
        for (int i = 0; i < 4; i++) mvalid[i] = 1'b0;
        exp_hit = '0; exp_miss = '0;
        @(negedge clk); #4 reset_n = 1'b1;

        access(1'b1, 1'b0, 16'h0025, 16'h0);
        check("post_rst_miss", miss_count, 1);
        check("post_rst_hit", hit_count, 0);
        check("post_rst_stall", last_stall, 4);
        check("post_rst_rdata", last_rdata, 16'h5555);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_data_cache.md
Name: pipeline_data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the 16-bit pipelined core's data-memory port (stage MEM) and the slow main memory.
- Serves read hits combinationally in the requesting cycle.
- Read misses fill a whole line from memory, and every write goes through to memory.
- cpu_ready low while a request is pending is the MEM-stage stall condition for the pipeline.

Parameters:
WORD_SIZE, 16, data/address width
LINES, 4, number of cache lines (power of 2)
WORDS_PER_LINE, 4, words per line (power of 2); line width = WORD_SIZE*WORDS_PER_LINE

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
cpu_read  input  1  read request, held until cpu_ready
cpu_write  input  1  write request, held until cpu_ready
cpu_addr  input  16  word address
cpu_wdata  input  16  write data
cpu_rdata  output  16  read data, valid when cpu_ready & cpu_read
cpu_ready  output  1  request completes at this rising edge
mem_read  output  1  line-fill request to memory
mem_write  output  1  single-word write-through request
mem_addr  output  16  line-aligned address (fill) or word address (write)
mem_wdata  output  16  write-through data
mem_rdata  input  64  full line from memory, valid with mem_ready
mem_ready  input  1  memory completes current request this cycle
hit_count  output  16  completed accesses that hit
miss_count  output  16  accesses that missed

Behaviour:
- Address split:
  - offset = addr[1:0]
  - index = addr[3:2]
  - tag = addr[15:4]
  - Derived widths come from log2 of the parameters.
- Per line state: valid bit, tag, data line. Line word k occupies mem_rdata[16k+15:16k].
- Reset (async):
  - All valid bits 0; state IDLE; hit_count = miss_count = 0.
  - mem_read = mem_write = 0; cpu_ready = 0; cpu_rdata = 0.
  - Reset mid-FILL/WRITE aborts the access; mem_* drop immediately.
- States: IDLE, FILL, WRITE.
- IDLE with no request: cpu_ready = 0, no memory activity.
- IDLE with cpu_read and a hit:
  - cpu_ready = 1 and cpu_rdata = cached word in the same cycle (0-cycle stall).
  - hit_count increments at the edge unless refill_flag is set; refill_flag clears at that edge.
- IDLE with cpu_read and a miss:
  - cpu_ready = 0; miss_count increments; go to FILL.
  - Latch the line-aligned address {tag,index,00}.
- FILL:
  - mem_read = 1, mem_addr = latched address; wait for mem_ready.
  - On mem_ready: write the line, set valid and tag, set refill_flag, go to IDLE. The read then completes as a hit in the next cycle.
  - Total stall = memory latency + 1 cycle.
- IDLE with cpu_write:
  - Go to WRITE; latch address and data.
  - On a hit, update the cached word at this edge. A miss does not allocate and increments miss_count; a hit increments hit_count.
- WRITE:
  - mem_write = 1, mem_addr and mem_wdata = latched values.
  - cpu_ready = mem_ready, combinational. On mem_ready go to IDLE.
- Simultaneous cpu_read and cpu_write: write wins, read ignored.
- Requester rules:
  - Requester must change or drop the request at the edge where cpu_ready = 1.
  - A request that is still held returns as a new access.
  - Changing cpu_addr while stalled is illegal; behaviour is undefined and not checked.
- mem_ready in IDLE is ignored.
- mem_read and mem_write are never high together.
- Counters saturate at 16'hFFFF.
- cpu_rdata = 0 when cpu_ready is low or for writes.

Decomposition:
- Shared package/header: WORD_SIZE, state encodings (IDLE = 0, FILL = 1, WRITE = 2), and the address-field width and position constants.
- One natural sub-module, cache_tag_data_array: valid, tag and data storage with async clear, a combinational lookup port (hit, word), a line-fill write port and a single-word write port.
- The FSM and counters stay in the top module.

Test Plan:
- Cold read: read 0x0025 after reset, memory returns line 0x0024–0x0027 = {0xAAA3, 0xAAA2, 0xAAA1, 0xAAA0} after 3 cycles.
  - Expect mem_read with mem_addr = 0x0024, cpu_ready after 4 cycles, cpu_rdata = 0xAAA1.
  - Expect miss_count = 1, hit_count = 0.
- Spatial hit: follow-up read 0x0026 → cpu_ready in the same cycle, cpu_rdata = 0xAAA2, no mem_read, hit_count = 1.
- Write-through hit: write 0x0026 = 0x1234 → mem_write with mem_addr = 0x0026, mem_wdata = 0x1234.
  - cpu_ready coincides with mem_ready; hit_count = 2.
  - Subsequent read 0x0026 returns 0x1234 with no fill.
- Conflict and no-allocate: write 0x0066 (same index, different tag) is a miss with no allocate. Then read 0x0066 → fill from 0x0064 and evict.
  - Read 0x0026 again → miss, refill.
  - Expected misses increase by 3.
- Reset mid-fill: assert reset_n = 0 during FILL → mem_read drops immediately and counters are 0. After release, read 0x0025 misses again.
- Priority and saturation:
  - cpu_read = cpu_write = 1 → only the write-through occurs.
  - Force hit_count to 0xFFFF (long hit loop or preload) → further hits keep it at 0xFFFF.
